// File: rtl/logic_reduce_acc_pkg.sv
// Shared definitions for the logic reduction accumulator: operator encodings
// and the frame state enumeration.
package logic_reduce_acc_pkg;

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/logic_reduce_comb.sv
// Combinational bitwise reduction of CHANNELS words with OR/AND/XOR.
// Encoding 11 falls through to OR.
module logic_reduce_comb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [1:0]                mode,
    output logic [WIDTH-1:0]          result
);
    import logic_reduce_acc_pkg::*;

    always_comb begin
        result = data[WIDTH-1:0];
        for (int k = 1; k < CHANNELS; k++) begin
            case (mode)
                MODE_AND: result = result & data[k*WIDTH +: WIDTH];
                MODE_XOR: result = result ^ data[k*WIDTH +: WIDTH];
                default:  result = result | data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/logic_reduce_acc.sv
// Frame accumulator: reduces each beat across channels, folds beats into a
// per-frame result with a saturating beat count, and presents it with a handshake.
module logic_reduce_acc #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                          out_overflow
);
    import logic_reduce_acc_pkg::*;

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_t         state;
    logic [1:0]     op_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [CW-1:0]  count_p0;
    logic           ovf_p0;

    logic [1:0]     beat_mode;
    logic [WIDTH-1:0] beat_val;
    logic [WIDTH-1:0] comb_val;
    logic [WIDTH-1:0] next_acc;
    logic [CW-1:0]  next_count;
    logic           next_ovf;
    logic           accept;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(MAX_BEATS)) ? c : c + 1'b1;
    endfunction

    assign accept = in_valid & in_ready;

    // The first beat of a frame uses the live mode; later beats use the latched one.
    assign beat_mode = (state == ST_IDLE) ? mode : op_p0;

    logic_reduce_comb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_chan (
        .data   (in_data),
        .mode   (beat_mode),
        .result (beat_val)
    );

    logic_reduce_comb #(.WIDTH(WIDTH), .CHANNELS(2)) u_fold (
        .data   ({beat_val, acc_p0}),
        .mode   (op_p0),
        .result (comb_val)
    );

    always_comb begin
        next_acc   = beat_val;
        next_count = CW'(1);
        next_ovf   = 1'b0;
        if (state == ST_ACCUM) begin
            next_acc   = comb_val;
            next_count = sat_inc(count_p0);
            next_ovf   = ovf_p0 | (count_p0 == CW'(MAX_BEATS));
        end
    end

    // ---- frame state / registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_p0        <= MODE_OR;
            acc_p0       <= '0;
            count_p0     <= '0;
            ovf_p0       <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_beats    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (state == ST_IDLE) op_p0 <= mode;
                        acc_p0   <= next_acc;
                        count_p0 <= next_count;
                        ovf_p0   <= next_ovf;
                        if (in_last) begin
                            state        <= ST_HOLD;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_data     <= next_acc;
                            out_beats    <= next_count;
                            out_overflow <= next_ovf;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state        <= ST_IDLE;
                        in_ready     <= 1'b1;
                        acc_p0       <= '0;
                        count_p0     <= '0;
                        ovf_p0       <= 1'b0;
                        out_valid    <= 1'b0;
                        out_data     <= '0;
                        out_beats    <= '0;
                        out_overflow <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed bench for logic_reduce_acc (WIDTH=8, CHANNELS=4, MAX_BEATS=16).
module tb_logic_reduce_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [4:0]  out_beats;
    logic        out_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic_reduce_acc #(.WIDTH(8), .CHANNELS(4), .MAX_BEATS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_beats    (out_beats),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // Present one beat for one clock edge, then withdraw it.
    task automatic beat(input logic [31:0] d, input logic [1:0] m, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data got %h want 00", out_data); end
        n_cmp++; if (out_beats !== 5'd0) begin n_bad++; $display("FAIL rst_out_beats got %0d want 0", out_beats); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %0b want 0", out_overflow); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_or_single();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL or_pre_valid got %0b want 0", out_valid); end
        beat(32'h08040201, 2'b00, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL or_latency got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'h0F) begin n_bad++; $display("FAIL or_data got %h want 0f", out_data); end
        n_cmp++; if (out_beats !== 5'd1) begin n_bad++; $display("FAIL or_beats got %0d want 1", out_beats); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL or_hold_ready got %0b want 0", in_ready); end
        pop();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL or_pop_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL or_pop_data got %h want 00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL or_pop_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_and_three();
        beat(32'hF8FCF0FF, 2'b01, 1'b0);
        beat(32'hFFFFFF3F, 2'b01, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL and_mid_valid got %0b want 0", out_valid); end
        beat(32'hFFFFFFFF, 2'b01, 1'b1);
        n_cmp++; if (out_data !== 8'h30) begin n_bad++; $display("FAIL and_data got %h want 30", out_data); end
        n_cmp++; if (out_beats !== 5'd3) begin n_bad++; $display("FAIL and_beats got %0d want 3", out_beats); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL and_overflow got %0b want 0", out_overflow); end
        pop();
    endtask

    task automatic test_xor_mode_switch();
        beat(32'h000055AA, 2'b10, 1'b0);
        beat(32'h0000000F, 2'b01, 1'b1);
        n_cmp++; if (out_data !== 8'hF0) begin n_bad++; $display("FAIL xor_data got %h want f0", out_data); end
        n_cmp++; if (out_beats !== 5'd2) begin n_bad++; $display("FAIL xor_beats got %0d want 2", out_beats); end
        pop();
    endtask

    task automatic test_backpressure();
        beat(32'h00000033, 2'b00, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %0b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 8'h33) begin n_bad++; $display("FAIL bp_data[%0d] got %h want 33", i, out_data); end
            n_cmp++; if (out_beats !== 5'd1) begin n_bad++; $display("FAIL bp_beats[%0d] got %0d want 1", i, out_beats); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_done_ready got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_accept got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) beat(32'h00000001, 2'b00, (i == 15));
        n_cmp++; if (out_beats !== 5'd16) begin n_bad++; $display("FAIL exact16_beats got %0d want 16", out_beats); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL exact16_overflow got %0b want 0", out_overflow); end
        pop();
        for (int i = 0; i < 20; i++) beat(32'h00000001, 2'b00, (i == 19));
        n_cmp++; if (out_beats !== 5'd16) begin n_bad++; $display("FAIL ovf_beats got %0d want 16", out_beats); end
        n_cmp++; if (out_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0b want 1", out_overflow); end
        n_cmp++; if (out_data !== 8'h01) begin n_bad++; $display("FAIL ovf_data got %h want 01", out_data); end
        pop();
    endtask

    task automatic test_reset_mid();
        beat(32'hFFFFFFFF, 2'b01, 1'b0);
        beat(32'hFFFFFFFF, 2'b01, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_back got %0b want 1", in_ready); end
        beat(32'h00000010, 2'b00, 1'b1);
        n_cmp++; if (out_data !== 8'h10) begin n_bad++; $display("FAIL midrst_data got %h want 10", out_data); end
        n_cmp++; if (out_beats !== 5'd1) begin n_bad++; $display("FAIL midrst_beats got %0d want 1", out_beats); end
        pop();
    endtask

    initial begin
        test_reset();
        test_or_single();
        test_and_three();
        test_xor_mode_switch();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
